// File: rtl/lq_idx_alloc.sv
// Load-queue index allocator and occupancy tracker.
// Hands out consecutive lqIdx_t values (flipped bit + index) to dispatched
// load lanes, frees entries in order at the head on commit, and rolls the
// tail back on a squash. Head, tail and count are register-derived.

// One dispatch lane: its lqIdx is the tail plus the number of valid lanes
// below it, so valid lanes receive consecutive indices in lane order.
module lq_idx_lane #(
    parameter int PW = 7,
    parameter int NW = 3
) (
    input  logic [PW-1:0] tail,
    input  logic [NW-1:0] ofs,
    output logic [PW-1:0] idx
);
    // PW-bit add: the flipped bit toggles when the index wraps
    assign idx = tail + {{(PW-NW){1'b0}}, ofs};
endmodule

module lq_idx_alloc #(
    parameter int LQSIZE       = 64,
    parameter int DISP_WIDTH   = 4,
    parameter int COMMIT_WIDTH = 4,
    localparam int IW = $clog2(LQSIZE),
    localparam int PW = IW + 1,
    localparam int CW = $clog2(COMMIT_WIDTH) + 1,
    localparam int NW = $clog2(DISP_WIDTH) + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DISP_WIDTH-1:0]            i_alloc_vld,
    output logic                             o_can_alloc,
    output logic [DISP_WIDTH-1:0][PW-1:0]    o_alloc_lqIdx,
    input  logic [CW-1:0]                    i_commit_num,
    input  logic                             i_squash_vld,
    input  logic [PW-1:0]                    i_squash_lqIdx,
    output logic [PW-1:0]                    o_head,
    output logic [PW-1:0]                    o_tail,
    output logic [IW:0]                      o_count,
    output logic                             o_empty,
    output logic                             o_full
);
    localparam logic [IW:0] LQ_N = (IW+1)'(LQSIZE);

    logic [PW-1:0]                head;
    logic [PW-1:0]                tail;
    logic [DISP_WIDTH:0][NW-1:0]  pre;
    logic [NW-1:0]                n;
    logic [IW:0]                  count;
    logic [IW:0]                  free;
    logic                         can_alloc;
    logic                         fire;
    logic [PW-1:0]                head_nxt;

    // Running popcount of the request vector; pre[i] = valid lanes below i
    always_comb begin
        pre[0] = '0;
        for (int i = 0; i < DISP_WIDTH; i++)
            pre[i+1] = pre[i] + {{(NW-1){1'b0}}, i_alloc_vld[i]};
    end

    assign n = pre[DISP_WIDTH];

    for (genvar g = 0; g < DISP_WIDTH; g++) begin : g_lane
        lq_idx_lane #(.PW(PW), .NW(NW)) u_lane (
            .tail (tail),
            .ofs  (pre[g]),
            .idx  (o_alloc_lqIdx[g])
        );
    end

    // Occupancy from registered pointers only; same-cycle commit adds no room
    assign count     = {tail[PW-1] ^ head[PW-1], tail[IW-1:0]} - {1'b0, head[IW-1:0]};
    assign free      = LQ_N - count;
    assign can_alloc = !i_squash_vld && (free >= {{(IW+1-NW){1'b0}}, n});
    assign fire      = can_alloc && (n != '0);
    assign head_nxt  = head + {{(PW-CW){1'b0}}, i_commit_num};

    // Pointer registers: commit always advances head; squash beats allocate
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
        end else begin
            head <= head_nxt;
            if (i_squash_vld)
                tail <= i_squash_lqIdx;
            else if (fire)
                tail <= tail + {{(PW-NW){1'b0}}, n};
        end
    end

    assign o_can_alloc = can_alloc;
    assign o_head      = head;
    assign o_tail      = tail;
    assign o_count     = count;
    assign o_empty     = (count == '0);
    assign o_full      = (count == LQ_N);

    logic [PW-1:0] sq_dist;
    logic [PW-1:0] live_dist;
    logic [PW-1:0] ptr_diff;
    assign sq_dist   = i_squash_lqIdx - head_nxt;
    assign live_dist = tail - head_nxt;
    assign ptr_diff  = tail - head;

    a_commit_le_count: assert property (@(posedge clk) disable iff (rst)
        {{(IW+1-CW){1'b0}}, i_commit_num} <= count);
    a_squash_in_range: assert property (@(posedge clk) disable iff (rst)
        i_squash_vld |-> (sq_dist <= live_dist));
    a_count_bounded: assert property (@(posedge clk) disable iff (rst)
        ptr_diff <= PW'(LQSIZE));
endmodule

// File: tb/tb_lq_idx_alloc.sv
// Scoreboard bench for lq_idx_alloc: each drive pushes the expected
// combinational outputs and pre-edge pointer state; tests pop and compare.
module tb_lq_idx_alloc;
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      i_alloc_vld = '0;
    logic [2:0]      i_commit_num = '0;
    logic            i_squash_vld = 1'b0;
    logic [6:0]      i_squash_lqIdx = '0;
    logic            o_can_alloc;
    logic [3:0][6:0] o_alloc_lqIdx;
    logic [6:0]      o_head, o_tail, o_count;
    logic            o_empty, o_full;

    lq_idx_alloc dut (
        .clk(clk), .rst(rst), .i_alloc_vld(i_alloc_vld), .o_can_alloc(o_can_alloc),
        .o_alloc_lqIdx(o_alloc_lqIdx), .i_commit_num(i_commit_num),
        .i_squash_vld(i_squash_vld), .i_squash_lqIdx(i_squash_lqIdx),
        .o_head(o_head), .o_tail(o_tail), .o_count(o_count),
        .o_empty(o_empty), .o_full(o_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            can;
        bit [3:0]      vld;
        bit [3:0][6:0] idx;
        bit [6:0]      head, tail, count;
    } exp_t;

    exp_t     exp_q[$];
    int       nvec = 0;
    int       nbad = 0;
    bit [6:0] m_head = '0;
    bit [6:0] m_tail = '0;

    // Drive one cycle of stimulus, record expectations, advance the model
    task automatic apply(input bit [3:0] vld, input bit [2:0] cn = 3'd0,
                         input bit sq = 1'b0, input bit [6:0] sqi = 7'd0);
        exp_t     e;
        int       n = 0;
        bit [6:0] cnt;
        @(posedge clk); #1;
        i_alloc_vld = vld; i_commit_num = cn; i_squash_vld = sq; i_squash_lqIdx = sqi;
        cnt = m_tail - m_head;
        for (int i = 0; i < 4; i++) begin
            e.idx[i] = m_tail + 7'(n);
            n += int'(vld[i]);
        end
        e.can = !sq && ((64 - int'(cnt)) >= n);
        e.vld = vld; e.head = m_head; e.tail = m_tail; e.count = cnt;
        exp_q.push_back(e);
        m_head = m_head + 7'(cn);
        if (sq) m_tail = sqi;
        else if (e.can && n != 0) m_tail = m_tail + 7'(n);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        i_alloc_vld = 4'($urandom); i_commit_num = 3'($urandom);
        i_squash_vld = 1'b0; i_squash_lqIdx = 7'($urandom);
        @(posedge clk); #1;
        i_alloc_vld = 4'($urandom); i_commit_num = 3'($urandom);
        @(negedge clk);
        nvec++; if (o_head !== 7'h00) begin nbad++; $display("FAIL reset_head act=%h req=00", o_head); end
        nvec++; if (o_tail !== 7'h00) begin nbad++; $display("FAIL reset_tail act=%h req=00", o_tail); end
        nvec++; if (o_count !== 7'd0) begin nbad++; $display("FAIL reset_count act=%0d req=0", o_count); end
        nvec++; if (o_empty !== 1'b1 || o_full !== 1'b0) begin nbad++; $display("FAIL reset_flags act=%b%b req=10", o_empty, o_full); end
        nvec++; if (o_can_alloc !== 1'b1) begin nbad++; $display("FAIL reset_can act=%b req=1", o_can_alloc); end
        @(posedge clk); #1;
        rst = 1'b0;
        i_alloc_vld = '0; i_commit_num = '0; i_squash_vld = 1'b0; i_squash_lqIdx = '0;
        m_head = '0; m_tail = '0;
        @(negedge clk);
    endtask

    task automatic test_sparse();
        exp_t e;
        apply(4'b1010);
        e = exp_q.pop_front();
        nvec++; if (o_can_alloc !== e.can) begin nbad++; $display("FAIL sparse_can act=%b req=%b", o_can_alloc, e.can); end
        nvec++; if (o_alloc_lqIdx[1] !== 7'h00) begin nbad++; $display("FAIL sparse_lane1 act=%h req=00", o_alloc_lqIdx[1]); end
        nvec++; if (o_alloc_lqIdx[3] !== 7'h01) begin nbad++; $display("FAIL sparse_lane3 act=%h req=01", o_alloc_lqIdx[3]); end
        apply(4'b0000);
        e = exp_q.pop_front();
        nvec++; if (o_tail !== 7'h02 || o_tail !== e.tail) begin nbad++; $display("FAIL sparse_tail act=%h req=02", o_tail); end
        nvec++; if (o_count !== 7'd2) begin nbad++; $display("FAIL sparse_count act=%0d req=2", o_count); end
    endtask

    task automatic test_full();
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            apply(4'b1111);
            e = exp_q.pop_front();
            nvec++; if (o_can_alloc !== e.can) begin nbad++; $display("FAIL fill_can[%0d] act=%b req=%b", i, o_can_alloc, e.can); end
        end
        apply(4'b0001);
        e = exp_q.pop_front();
        nvec++; if (o_full !== 1'b1) begin nbad++; $display("FAIL full_flag act=%b req=1", o_full); end
        nvec++; if (o_tail !== 7'h40) begin nbad++; $display("FAIL full_tail act=%h req=40", o_tail); end
        nvec++; if (o_can_alloc !== 1'b0 || e.can !== 1'b0) begin nbad++; $display("FAIL full_can act=%b req=0", o_can_alloc); end
        apply(4'b0001, 3'd4);
        e = exp_q.pop_front();
        nvec++; if (o_can_alloc !== 1'b0) begin nbad++; $display("FAIL full_commit_can act=%b req=0", o_can_alloc); end
        apply(4'b0000);
        e = exp_q.pop_front();
        nvec++; if (o_tail !== 7'h40) begin nbad++; $display("FAIL full_hold_tail act=%h req=40", o_tail); end
        nvec++; if (o_head !== 7'h04 || o_count !== 7'd60) begin nbad++; $display("FAIL full_drain act=%h/%0d req=04/60", o_head, o_count); end
    endtask

    task automatic test_near_full();
        exp_t e;
        for (int i = 0; i < 15; i++) begin
            apply(4'b1111, (i == 0) ? 3'd0 : 3'd4);
            void'(exp_q.pop_front());
        end
        apply(4'b0000, 3'd4);
        void'(exp_q.pop_front());
        for (int i = 0; i < 16; i++) begin
            apply((i < 15) ? 4'b1111 : 4'b0011);
            e = exp_q.pop_front();
            nvec++; if (o_can_alloc !== e.can) begin nbad++; $display("FAIL nf_ramp_can[%0d] act=%b req=%b", i, o_can_alloc, e.can); end
        end
        apply(4'b1111);
        e = exp_q.pop_front();
        nvec++; if (o_head !== 7'h3C || o_count !== 7'd62) begin nbad++; $display("FAIL nf_state act=%h/%0d req=3c/62", o_head, o_count); end
        nvec++; if (o_can_alloc !== 1'b0) begin nbad++; $display("FAIL nf_block act=%b req=0", o_can_alloc); end
        apply(4'b1111, 3'd2);
        e = exp_q.pop_front();
        nvec++; if (o_can_alloc !== 1'b0) begin nbad++; $display("FAIL nf_commit_block act=%b req=0", o_can_alloc); end
        apply(4'b1111);
        e = exp_q.pop_front();
        nvec++; if (o_count !== 7'd60) begin nbad++; $display("FAIL nf_count60 act=%0d req=60", o_count); end
        nvec++; if (o_can_alloc !== 1'b1) begin nbad++; $display("FAIL nf_retry_can act=%b req=1", o_can_alloc); end
        nvec++; if (o_alloc_lqIdx[0] !== e.idx[0] || o_alloc_lqIdx[3] !== e.idx[3]) begin nbad++; $display("FAIL nf_idx act=%h,%h req=%h,%h", o_alloc_lqIdx[0], o_alloc_lqIdx[3], e.idx[0], e.idx[3]); end
        apply(4'b0000);
        e = exp_q.pop_front();
        nvec++; if (o_full !== 1'b1 || o_count !== e.count) begin nbad++; $display("FAIL nf_full act=%b/%0d req=1/%0d", o_full, o_count, e.count); end
    endtask

    task automatic test_wrap();
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            apply((i < 15) ? 4'b1111 : 4'b0011, (i == 0) ? 3'd0 : 3'd4);
            void'(exp_q.pop_front());
        end
        apply(4'b0000, 3'd2);
        void'(exp_q.pop_front());
        apply(4'b1111);
        e = exp_q.pop_front();
        nvec++; if (o_head !== 7'h3E || o_tail !== 7'h3E) begin nbad++; $display("FAIL wrap_start act=%h/%h req=3e/3e", o_head, o_tail); end
        nvec++; if (o_alloc_lqIdx !== {7'h41, 7'h40, 7'h3F, 7'h3E}) begin nbad++; $display("FAIL wrap_idx act=%h req=%h", o_alloc_lqIdx, {7'h41, 7'h40, 7'h3F, 7'h3E}); end
        apply(4'b0000);
        e = exp_q.pop_front();
        nvec++; if (o_count !== 7'd4 || o_tail !== 7'h42) begin nbad++; $display("FAIL wrap_after act=%0d/%h req=4/42", o_count, o_tail); end
    endtask

    task automatic test_squash();
        exp_t e;
        apply(4'b1111);
        apply(4'b1111, 3'd4);
        apply(4'b1111);
        apply(4'b1111);
        repeat (4) void'(exp_q.pop_front());
        apply(4'b1111, 3'd2, 1'b1, 7'h08);
        e = exp_q.pop_front();
        nvec++; if (o_tail !== 7'h10 || o_head !== 7'h04) begin nbad++; $display("FAIL sq_state act=%h/%h req=10/04", o_tail, o_head); end
        nvec++; if (o_can_alloc !== 1'b0) begin nbad++; $display("FAIL sq_can act=%b req=0", o_can_alloc); end
        apply(4'b0000);
        e = exp_q.pop_front();
        nvec++; if (o_tail !== 7'h08 || o_head !== 7'h06 || o_count !== 7'd2) begin nbad++; $display("FAIL sq_after act=%h/%h/%0d req=08/06/2", o_tail, o_head, o_count); end
    endtask

    task automatic test_back_to_back();
        exp_t     e;
        bit [6:0] cnt, nh, live;
        bit [2:0] cn;
        bit       sq;
        bit [6:0] sqi;
        for (int c = 0; c < 120; c++) begin
            cnt = m_tail - m_head;
            cn  = ($urandom_range(2, 0) == 0) ? 3'($urandom_range((cnt > 4) ? 4 : int'(cnt), 0)) : 3'd0;
            sq  = ($urandom_range(9, 0) == 0);
            nh  = m_head + 7'(cn);
            live = m_tail - nh;
            sqi = nh + 7'($urandom_range(int'(live), 0));
            apply(4'($urandom), cn, sq, sqi);
            e = exp_q.pop_front();
            nvec++; if (o_can_alloc !== e.can) begin nbad++; $display("FAIL b2b_can[%0d] act=%b req=%b", c, o_can_alloc, e.can); end
            nvec++; if (o_head !== e.head || o_tail !== e.tail) begin nbad++; $display("FAIL b2b_ptr[%0d] act=%h/%h req=%h/%h", c, o_head, o_tail, e.head, e.tail); end
            nvec++; if (o_count !== e.count || o_empty !== (e.count == 0) || o_full !== (e.count == 64)) begin nbad++; $display("FAIL b2b_count[%0d] act=%0d/%b%b req=%0d", c, o_count, o_empty, o_full, e.count); end
            for (int i = 0; i < 4; i++) begin
                if (e.vld[i]) begin
                    nvec++; if (o_alloc_lqIdx[i] !== e.idx[i]) begin nbad++; $display("FAIL b2b_idx[%0d][%0d] act=%h req=%h", c, i, o_alloc_lqIdx[i], e.idx[i]); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_sparse();
        test_reset();
        test_full();
        test_reset();
        test_near_full();
        test_reset();
        test_wrap();
        test_reset();
        test_squash();
        test_reset();
        test_back_to_back();
        test_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule

// File: doc/lq_idx_alloc.md
Name: lq_idx_alloc

Overview:
- Load-queue index allocator and occupancy tracker. It sits between rename/dispatch and the load queue.
- Each cycle it hands out up to DISP_WIDTH consecutive lqIdx_t values (flipped bit + index) to the load uops being dispatched.
- It retires entries in order at the head on commit, and rolls the tail back on a pipeline squash.
- The load queue, ROB and memory dependence logic consume its head, tail and age information.

Parameters:
- LQSIZE, 64: number of load-queue entries; must be a power of two. Index width IW = log2(LQSIZE) = 6; pointer width PW = IW+1 = 7.
- DISP_WIDTH, 4: number of dispatch lanes.
- COMMIT_WIDTH, 4: maximum loads committed per cycle.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- i_alloc_vld  in  DISP_WIDTH  per-lane load allocation request; any bit pattern is legal.
- o_can_alloc  out  1  asserted when there is room for every requested lane this cycle.
- o_alloc_lqIdx  out  DISP_WIDTH x PW  lqIdx_t assigned to each lane; meaningful only for valid lanes.
- i_commit_num  in  log2(COMMIT_WIDTH)+1  number of head entries freed this cycle.
- i_squash_vld  in  1  squash request.
- i_squash_lqIdx  in  PW  first lqIdx_t to discard; it becomes the new tail.
- o_head  out  PW  oldest live entry.
- o_tail  out  PW  next entry to allocate.
- o_count  out  IW+1  number of live entries.
- o_empty  out  1  o_count == 0.
- o_full  out  1  o_count == LQSIZE.

Behaviour:
- Reset, synchronous to clk: head = 0 and tail = 0, with both flipped bits 0. Outputs then read o_count = 0, o_empty = 1, o_full = 0.
- Pointer arithmetic:
  - Adding k to a pointer is a PW-bit add; the flipped bit toggles whenever the index wraps past LQSIZE-1.
  - count = {tail.flipped ^ head.flipped, tail.idx} - {1'b0, head.idx}, computed in IW+1 bits.
- Allocation:
  - n = popcount(i_alloc_vld).
  - o_can_alloc = !i_squash_vld && (LQSIZE - count) >= n. This is combinational from registered state; the same-cycle commit does not create extra room.
  - o_alloc_lqIdx[i] = tail + popcount(i_alloc_vld[i-1:0]), so valid lanes receive consecutive indices in lane order. Invalid lanes output the same value as the next valid lane would receive; this value is don't-care.
  - Allocation fires when o_can_alloc && n != 0. On a fire, tail <= tail + n at the next edge.
  - When o_can_alloc = 0, no lane allocates (all-or-nothing) and tail is held. The upstream stage stalls and re-presents the request.
- Commit:
  - head <= head + i_commit_num every cycle, independent of allocation and squash.
  - Precondition: i_commit_num <= count. A simulation assertion fires if this is violated; behaviour is undefined in that case.
- Squash:
  - tail <= i_squash_lqIdx, and allocation is suppressed that cycle.
  - Precondition: i_squash_lqIdx lies in [head + i_commit_num, tail] in circular order. Squashing to tail is a no-op; squashing to head empties the queue. Both are asserted in simulation.
- Simultaneous events:
  - Commit + allocate in the same cycle: both apply; next count = count + n - commit_num.
  - Commit + squash in the same cycle: both apply.
  - Squash has priority over allocate.
- Full boundary:
  - With count == LQSIZE, o_full = 1, and o_can_alloc = 0 for any n > 0 even if commit_num > 0 in the same cycle.
  - With n == 0, o_can_alloc = 1 when not squashing.
- Output timing: o_head, o_tail, o_count, o_empty and o_full are derived from registers only and are stable for the whole cycle. Latency from request to pointer update is 1 cycle.
- Reset asserted mid-operation overrides every concurrent commit, allocate and squash at that edge.
- Invariant: 0 <= count <= LQSIZE at every edge, checked by an assertion.

Test Plan:
- Reset with random inputs held -> after the first edge, head = tail = 7'h00, o_count = 0, o_empty = 1, o_can_alloc = 1.
- From empty, i_alloc_vld = 4'b1010 -> lane1 gets 0x00 and lane3 gets 0x01; the next cycle shows tail = 0x02 and count = 2.
- Allocate 4 per cycle for 16 cycles -> o_full = 1 and tail = 7'h40 (flipped = 1, idx = 0). A further request of 4'b0001 gives o_can_alloc = 0, and tail is unchanged.
- At count = 62 with head = 0x3C, request 4'b1111 -> o_can_alloc = 0. Then commit 2 and request 4'b1111 together -> still blocked that cycle; count goes to 60. The next cycle the allocation succeeds.
- Wrap-around: head = tail = 0x3E, allocate 4 -> indices 0x3E, 0x3F, 0x40, 0x41 (flipped toggles); count = 4.
- tail = 0x10 and head = 0x04, squash to 0x08 while also requesting 4'b1111 and committing 2 -> o_can_alloc = 0; next cycle tail = 0x08, head = 0x06, count = 2.
